// File: rtl/beta_dcache_pkg.sv
// Shared types, widths and address helpers for the Beta data cache.
package beta_dcache_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_t;

    // Line index: word address bits above the byte offset, idx_w bits wide.
    function automatic logic [WORD_W-1:0] addr_index(input logic [WORD_W-1:0] addr,
                                                     input int unsigned idx_w);
        return (addr >> 2) & ((WORD_W'(1) << idx_w) - WORD_W'(1));
    endfunction

    // Tag: everything above the index bits.
    function automatic logic [WORD_W-1:0] addr_tag(input logic [WORD_W-1:0] addr,
                                                   input int unsigned idx_w);
        return addr >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/beta_dcache_if.sv
// Core data port plus memory req/ack bus as seen by the data cache.
interface beta_dcache_if;
    import beta_dcache_pkg::*;

    logic [WORD_W-1:0] cpu_addr;
    logic [WORD_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic              cpu_re;
    logic [WORD_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;

    // Cache side: answers the core, drives the memory request.
    modport master (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_ack, mem_rdata,
        output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    // Environment side: core requests and memory responses.
    modport slave (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_ack, mem_rdata,
        input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/beta_dcache_array.sv
// Valid/tag/data storage: combinational read at rd_idx, one write port.
// Only the valid bits are reset; tags and data are left as-is.
module beta_dcache_array
    import beta_dcache_pkg::*;
#(
    parameter int unsigned LINES = 64,
    parameter int unsigned IDX   = $clog2(LINES),
    parameter int unsigned TAG   = 30 - IDX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX-1:0]    rd_idx,
    output logic              rd_valid,
    output logic [TAG-1:0]    rd_tag,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX-1:0]    wr_idx,
    input  logic [TAG-1:0]    wr_tag,
    input  logic [WORD_W-1:0] wr_data
);

    logic [LINES-1:0]  valid;
    logic [TAG-1:0]    tags [LINES];
    logic [WORD_W-1:0] data [LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

    // Valid bits: cleared by reset, set on any line write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage, no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/beta_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the Beta core.
// Optional build macro: DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module beta_dcache
    import beta_dcache_pkg::*;
#(
    parameter int unsigned LINES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    beta_dcache_if.master    bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
`endif
);

    localparam int unsigned IDX = $clog2(LINES);
    localparam int unsigned TAG = 30 - IDX;

    state_t            state;
    logic [WORD_W-1:0] rdata;
    logic [WORD_W-1:0] maddr;
    logic [WORD_W-1:0] mwdata;
    logic              mwe;

    logic [WORD_W-1:0] lk_addr;
    logic [IDX-1:0]    lk_idx;
    logic [TAG-1:0]    lk_tag;
    logic              rd_valid;
    logic [TAG-1:0]    rd_tag;
    logic [WORD_W-1:0] rd_data;
    logic              hit;
    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic              stall;

    // In IDLE look up the live core address; while busy, the latched one.
    assign lk_addr = (state == IDLE) ? bus.cpu_addr : maddr;
    assign lk_idx  = IDX'(addr_index(lk_addr, IDX));
    assign lk_tag  = TAG'(addr_tag(lk_addr, IDX));
    assign hit     = rd_valid && (rd_tag == lk_tag);

    // Refill on a read ack; update only on a write-through that hits.
    assign wr_en   = bus.mem_ack && ((state == RD_MISS) || ((state == WR_THRU) && hit));
    assign wr_data = (state == RD_MISS) ? bus.mem_rdata : mwdata;

    beta_dcache_array #(
        .LINES (LINES),
        .IDX   (IDX),
        .TAG   (TAG)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (lk_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (lk_idx),
        .wr_tag   (lk_tag),
        .wr_data  (wr_data)
    );

    // Stall: stores and load misses in IDLE, every busy cycle until the ack.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = bus.cpu_we || (bus.cpu_re && !hit);
            default: stall = !bus.mem_ack;
        endcase
    end

    // Controller state and registered core/memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rdata  <= '0;
            maddr  <= '0;
            mwdata <= '0;
            mwe    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_we) begin
                        maddr  <= {bus.cpu_addr[WORD_W-1:2], 2'b00};
                        mwdata <= bus.cpu_wdata;
                        mwe    <= 1'b1;
                        state  <= WR_THRU;
                    end else if (bus.cpu_re) begin
                        if (hit) begin
                            rdata <= rd_data;
                        end else begin
                            maddr <= {bus.cpu_addr[WORD_W-1:2], 2'b00};
                            mwe   <= 1'b0;
                            state <= RD_MISS;
                        end
                    end
                end
                RD_MISS: begin
                    if (bus.mem_ack) begin
                        rdata <= bus.mem_rdata;
                        state <= IDLE;
                    end
                end
                WR_THRU: begin
                    if (bus.mem_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_rdata = rdata;
    assign bus.cpu_stall = stall;
    assign bus.mem_req   = (state != IDLE);
    assign bus.mem_we    = mwe;
    assign bus.mem_addr  = maddr;
    assign bus.mem_wdata = mwdata;

`ifdef DCACHE_STATS_EN
    // Saturating counters of IDLE load hits and read-miss entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if ((state == IDLE) && !bus.cpu_we && bus.cpu_re) begin
            if (hit && (hit_count != '1)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (!hit && (miss_count != '1)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/beta_dcache.md
# beta_dcache

Direct-mapped, write-through, no-write-allocate data cache between the Beta core's data port and main memory. It replaces the core's direct single-cycle data path to memory so that main memory can have variable latency behind a req/ack handshake. A stall output holds the core while misses and write-throughs complete. The instruction port is not cached and is outside this block.

## Interface
Parameters:
- LINES, 64, number of one-word lines; power of two, at least 2. IDX = log2(LINES), TAG = 30 − IDX.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_addr  in  32  byte address; bits [1:0] ignored
- cpu_wdata  in  32  store data
- cpu_we  in  1  store request
- cpu_re  in  1  load request
- cpu_rdata  out  32  load data, registered
- cpu_stall  out  1  core must hold its request stable while high
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  32  word-aligned byte address
- mem_wdata  out  32  write data
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  32  read data, valid in the mem_ack cycle

## Operation
- Address split: index = addr[IDX+1:2], tag = addr[31:IDX+2]. A hit requires valid[index] set and a tag match.
- States: IDLE, RD_MISS, WR_THRU.
- IDLE, cpu_re hit: cpu_stall = 0. At the edge, cpu_rdata ← data[index]. State stays IDLE.
- IDLE, cpu_re miss: cpu_stall = 1. At the edge, latch addr into mem_addr and set mem_we = 0. Next state is RD_MISS.
- IDLE, cpu_we (hit or miss): cpu_stall = 1. At the edge, latch addr and wdata into mem_addr and mem_wdata, set mem_we = 1. Next state is WR_THRU.
- cpu_we and cpu_re both high: treated as a write; the read is ignored.
- RD_MISS: mem_req = 1. cpu_stall = !mem_ack. On the ack edge:
  - data[index] ← mem_rdata, tag written, valid set
  - cpu_rdata ← mem_rdata
  - next state IDLE
- WR_THRU: mem_req = 1. cpu_stall = !mem_ack. On the ack edge:
  - if the line hits, data[index] ← mem_wdata
  - a miss leaves the cache untouched (no allocate)
  - next state IDLE
- mem_ack while in IDLE is ignored.
- mem_req = (state != IDLE), decoded from the state register only.
- Reset (asynchronous, any state):
  - state → IDLE; all valid bits cleared
  - cpu_rdata, mem_addr, mem_wdata → 0; mem_we → 0
  - mem_req drops immediately
  - a pending ack arriving after reset is ignored
  - tag and data arrays are not reset

## Timing
- Load hit: request cycle N, no stall, cpu_rdata valid after edge N.
- Load miss: stall in cycle N plus every RD_MISS cycle before the ack. If memory acks in the first request cycle, the penalty is exactly 1 stall cycle.
- Store: stall in cycle N until the ack cycle. The minimum store cost is 1 stall cycle.
- cpu_stall is combinational from cpu_re, cpu_we, cpu_addr, the arrays, state and mem_ack. With no request in IDLE it is 0.
- mem_addr, mem_wdata and mem_we are stable for the whole mem_req window.

## Configuration
- DCACHE_STATS_EN defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each IDLE load hit.
  - miss_count increments on each RD_MISS entry.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Structure
- Package beta_dcache_pkg holds:
  - state enum (IDLE, RD_MISS, WR_THRU)
  - WORD_W = 32
  - helper functions for index and tag extraction, parameterised by IDX
- Sub-module beta_dcache_array holds the valid/tag/data storage:
  - combinational read port at index
  - one write port
  - valid clear on rst_n
- The FSM, stall logic and memory-side registers live in the top module.

## Test plan
- Cold read, memory word 0x100 = 0xDEADBEEF, ack after 3 cycles:
  - mem_req asserted with mem_addr = 0x100 and mem_we = 0
  - stall lasts 4 cycles
  - cpu_rdata = 0xDEADBEEF
  - a reread hits with no stall and no mem_req
- Store 0x12345678 to cached address 0x100:
  - one write with mem_we = 1 and mem_wdata = 0x12345678
  - a following load returns 0x12345678 as a hit with no mem_req
- Conflict with LINES = 64: load 0x100, then 0x200 (both index 0), then 0x100 → third access misses and issues mem_req.
- Store miss to 0x300: write-through issued; a following load of 0x300 misses (no allocate).
- Reset asserted in RD_MISS before the ack:
  - mem_req drops the same cycle
  - a late ack is ignored
  - a load to a previously cached address misses after release
- With DCACHE_STATS_EN, after the first scenario: hit_count = 1, miss_count = 1. A forced 0xFFFFFFFF holds on a further hit.
